// File: rtl/mdu_unit_pkg.sv
// Shared opcodes and default latencies for the multiply/divide unit.
// Opcodes are 4 bits wide so they can share a field with the ALU opcodes.
package mdu_unit_pkg;

    typedef enum logic [3:0] {
        mdu_none  = 4'd0,
        mdu_mult  = 4'd1,
        mdu_multu = 4'd2,
        mdu_div   = 4'd3,
        mdu_divu  = 4'd4,
        mdu_mthi  = 4'd5,
        mdu_mtlo  = 4'd6
    } mdu_op_e;

    localparam int MDU_MUL_LAT = 5;
    localparam int MDU_DIV_LAT = 10;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == mdu_div) || (op == mdu_divu);
    endfunction

endpackage

// File: rtl/mdu_unit_calc.sv
// Combinational arithmetic core: signed/unsigned multiply and divide,
// including the divide-by-zero and signed-overflow results.
module mdu_calc
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       mdop,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   b_safe;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic signed [WIDTH-1:0] q_s;
    logic signed [WIDTH-1:0] r_s;
    logic [WIDTH-1:0]   q_u;
    logic [WIDTH-1:0]   r_u;

    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    assign div_zero = (B == '0);
    assign div_ovf  = (A == MIN_NEG) && (B == ALL_ONE);

    // Special cases never reach the divider; a divisor of 1 keeps it well defined.
    assign b_safe = (div_zero || div_ovf) ? ONE : B;
    assign sa     = $signed(A);
    assign sb     = $signed(b_safe);
    assign q_s    = sa / sb;
    assign r_s    = sa % sb;
    assign q_u    = A / b_safe;
    assign r_u    = A % b_safe;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (mdop)
            mdu_mult:  {res_hi, res_lo} = prod_s;
            mdu_multu: {res_hi, res_lo} = prod_u;
            mdu_div: begin
                if (div_zero) begin
                    res_hi = A;
                    res_lo = ALL_ONE;
                end else if (div_ovf) begin
                    res_hi = '0;
                    res_lo = A;
                end else begin
                    res_hi = r_s;
                    res_lo = q_s;
                end
            end
            mdu_divu: begin
                if (div_zero) begin
                    res_hi = A;
                    res_lo = ALL_ONE;
                end else begin
                    res_hi = r_u;
                    res_lo = q_u;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit: latency counter, busy handshake and
// the architectural HI/LO registers.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = MDU_MUL_LAT,
    parameter int DIV_LAT = MDU_DIV_LAT,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       mdop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pending_hi;
    logic [WIDTH-1:0] pending_lo;
    logic [WIDTH-1:0] calc_hi;
    logic [WIDTH-1:0] calc_lo;

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .A      (A),
        .B      (B),
        .mdop   (mdop),
        .res_hi (calc_hi),
        .res_lo (calc_lo)
    );

    assign busy = (cnt != '0);

    // Result is computed at accept time and parked until the counter expires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
            HI         <= '0;
            LO         <= '0;
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                HI <= pending_hi;
                LO <= pending_lo;
            end
        end else if (start) begin
            case (mdop)
                mdu_mult, mdu_multu, mdu_div, mdu_divu: begin
                    pending_hi <= calc_hi;
                    pending_lo <= calc_lo;
                    cnt        <= is_div_op(mdop) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                end
                mdu_mthi: HI <= A;
                mdu_mtlo: LO <= A;
                default: ;
            endcase
        end
    end

endmodule
